// File: rtl/channel_arbiter.sv
// channel_arbiter
//   Shares one bidirectional output channel among N requesters. If the channel
//   is not currently turned toward this router, the block asks channel control
//   for it (arb_req) and then grants one requester. That requester keeps the
//   grant until it pulses pkt_done.
//   Requesters flagged in hp_mask win over the rest. Requesters are also
//   promoted to high priority once they have waited AGE_MAX cycles.
//   Requesters in the same priority class share the channel round-robin.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   channel_req  [N]   per-requester request level
//   hp_mask      [N]   1 = requester is high priority
//   chan_free          channel currently owned in our output direction
//   pkt_done           tail flit sent by the granted requester
//   arb_req            registered request to turn the channel toward us
//   grant        [N]   registered one-hot grant
//   grant_valid        |grant
//   grant_id     [$clog2(N)] index of the granted requester, 0 when idle
//
// state    | meaning
// IDLE     | no grant, nothing requested from channel control
// WAIT_DIR | requests pending, waiting for channel direction (arb_req=1)
// BUSY     | grant held until pkt_done
module channel_arbiter #(
    parameter int N       = 10,
    parameter int AGE_MAX = 15,
    localparam int IDW    = (N > 1) ? $clog2(N) : 1,
    localparam int AW     = $clog2(AGE_MAX + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   channel_req,
    input  logic [N-1:0]   hp_mask,
    input  logic           chan_free,
    input  logic           pkt_done,
    output logic           arb_req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    typedef enum logic [1:0] {IDLE, WAIT_DIR, BUSY} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [AW-1:0]  age [N];
    logic [N-1:0]   hp_eff;
    logic [N-1:0]   cand;
    logic [N-1:0]   win_oh;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic           any_req;
    logic           load_grant;

    assign any_req     = |channel_req;
    assign grant_valid = |grant;

    // Candidate class: aged or flagged requesters if any exist, else everyone.
    always_comb begin
        hp_eff = '0;
        for (int i = 0; i < N; i++) begin
            hp_eff[i] = channel_req[i] & (hp_mask[i] | (age[i] == AW'(AGE_MAX)));
        end
        cand = (|hp_eff) ? hp_eff : channel_req;
    end

    // Round-robin search starting at ptr and wrapping past N-1.
    always_comb begin
        int idx;
        idx       = 0;
        win_oh    = '0;
        win_id    = '0;
        win_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!win_found && cand[idx]) begin
                win_found   = 1'b1;
                win_oh[idx] = 1'b1;
                win_id      = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        load_grant = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (chan_free) begin
                        load_grant = 1'b1;
                        state_nxt  = BUSY;
                    end else begin
                        state_nxt  = WAIT_DIR;
                    end
                end
            end
            WAIT_DIR: begin
                if (!any_req) begin
                    state_nxt = IDLE;
                end else if (chan_free) begin
                    load_grant = 1'b1;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                if (pkt_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            arb_req  <= 1'b0;
            ptr      <= '0;
            for (int i = 0; i < N; i++) begin
                age[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            arb_req <= (state_nxt == WAIT_DIR);

            if (load_grant) begin
                grant    <= win_oh;
                grant_id <= win_id;
                ptr      <= (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
            end else if (state == BUSY && pkt_done) begin
                grant    <= '0;
                grant_id <= '0;
            end

            // The requester holding the grant does not age; it was cleared at load.
            for (int i = 0; i < N; i++) begin
                if (!channel_req[i] || (load_grant && win_oh[i])) begin
                    age[i] <= '0;
                end else if (!grant[i] && age[i] != AW'(AGE_MAX)) begin
                    age[i] <= age[i] + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_channel_arbiter.sv
module tb_channel_arbiter;

    localparam int N       = 10;
    localparam int AGE_MAX = 15;
    localparam int IDW     = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   channel_req;
    logic [N-1:0]   hp_mask;
    logic           chan_free;
    logic           pkt_done;
    logic           arb_req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    always #5 clk = ~clk;

    channel_arbiter #(.N(N), .AGE_MAX(AGE_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .channel_req (channel_req),
        .hp_mask     (hp_mask),
        .chan_free   (chan_free),
        .pkt_done    (pkt_done),
        .arb_req     (arb_req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the channel (-1 = nobody), rotation start,
    // cycles each requester has waited, and whether we are asking for direction.
    int m_owner;
    int m_ptr;
    int m_age [N];
    bit m_dir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input logic [N-1:0] hp);
        logic [N-1:0] hpe;
        logic [N-1:0] cls;
        for (int i = 0; i < N; i++) begin
            hpe[i] = req[i] && (hp[i] || m_age[i] == AGE_MAX);
        end
        cls = (hpe != 0) ? hpe : req;
        for (int k = 0; k < N; k++) begin
            if (cls[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] req, input logic [N-1:0] hp,
                              input logic f, input logic d);
        int new_owner;
        int loaded;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_dir   = 0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
            return;
        end
        new_owner = m_owner;
        loaded    = -1;
        if (m_owner >= 0) begin
            if (d) new_owner = -1;
        end else if (req != 0) begin
            if (f) begin
                loaded    = pick(req, hp);
                new_owner = loaded;
                m_ptr     = (loaded + 1) % N;
                m_dir     = 0;
            end else begin
                m_dir = 1;
            end
        end else begin
            m_dir = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (!req[i] || i == loaded) m_age[i] = 0;
            else if (i != m_owner && m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
        end
        m_owner = new_owner;
    endtask

    function automatic logic [31:0] exp_word();
        logic [31:0] w;
        w = '0;
        if (m_owner >= 0) begin
            w[m_owner] = 1'b1;
            w[13:10]   = 4'(m_owner);
            w[14]      = 1'b1;
        end
        w[15] = m_dir;
        return w;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] q, input logic [N-1:0] h,
                        input logic f, input logic d, input string tag);
        rst         = r;
        channel_req = q;
        hp_mask     = h;
        chan_free   = f;
        pkt_done    = d;
        @(posedge clk);
        model_step(r, q, h, f, d);
        #1;
        chk(tag, {16'b0, arb_req, grant_valid, grant_id, grant}, exp_word());
        chk({tag, "_onehot"}, 32'($onehot0(grant)), 32'd1);
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, 1'b0, 1'b0, "rst");
    endtask

    initial begin
        int n1;
        int seen0;
        logic [N-1:0] rq;
        logic [N-1:0] hq;

        m_owner = -1;
        m_ptr   = 0;
        m_dir   = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;

        // Reset held with every input active.
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 10'h3FF, '0, 1'b1, 1'b1, "rst_hold");
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_arb", 32'(arb_req), 32'h0);
        end
        step(1'b0, 10'h3FF, '0, 1'b1, 1'b0, "first_grant");
        chk("first_grant_val", 32'(grant), 32'h001);

        // Direct grant and release.
        do_reset();
        step(1'b0, 10'h001, '0, 1'b1, 1'b0, "direct");
        chk("direct_id", {grant_valid, grant_id, grant}, {1'b1, 4'd0, 10'h001});
        step(1'b0, 10'h001, '0, 1'b1, 1'b1, "direct_done");
        chk("direct_rel", {grant_valid, grant_id, grant}, 32'h0);

        // Direction request.
        do_reset();
        step(1'b0, 10'h001, '0, 1'b0, 1'b0, "dir_req");
        chk("dir_arb", 32'(arb_req), 32'h1);
        step(1'b0, 10'h001, '0, 1'b0, 1'b1, "dir_wait");
        chk("dir_arb_hold", 32'(arb_req), 32'h1);
        step(1'b0, 10'h001, '0, 1'b1, 1'b0, "dir_grant");
        chk("dir_grant_val", {arb_req, grant}, {1'b0, 10'h001});

        // Round-robin over all requesters with a gap cycle after each release.
        do_reset();
        for (int k = 0; k <= N; k++) begin
            step(1'b0, 10'h3FF, '0, 1'b1, 1'b0, "rr_grant");
            chk("rr_id", 32'(grant_id), 32'(k % N));
            step(1'b0, 10'h3FF, '0, 1'b1, 1'b1, "rr_done");
            chk("rr_gap", 32'(grant_valid), 32'h0);
        end

        // Priority then aging: requester 1 wins until requester 0 has waited 15 cycles.
        do_reset();
        n1    = 0;
        seen0 = 0;
        for (int c = 0; c < 40 && !seen0; c++) begin
            step(1'b0, 10'h003, 10'h002, 1'b1, 1'b0, "age_grant");
            if (c == 0) chk("hp_first", 32'(grant_id), 32'd1);
            if (grant == 10'h002) n1++;
            if (grant == 10'h001) seen0 = 1;
            step(1'b0, 10'h003, 10'h002, 1'b1, 1'b1, "age_done");
        end
        chk("age_seen0", 32'(seen0), 32'd1);
        chk("age_n1", 32'(n1), 32'd8);

        // Reset in the middle of a grant.
        do_reset();
        step(1'b0, 10'h3FF, '0, 1'b1, 1'b0, "mid_a");
        step(1'b0, 10'h3FF, '0, 1'b1, 1'b1, "mid_b");
        step(1'b0, 10'h3FF, '0, 1'b1, 1'b0, "mid_c");
        step(1'b0, 10'h3FF, '0, 1'b1, 1'b1, "mid_d");
        step(1'b0, 10'h004, '0, 1'b1, 1'b0, "mid_e");
        chk("mid_grant4", 32'(grant), 32'h004);
        step(1'b1, 10'h3FF, '0, 1'b1, 1'b0, "mid_rst");
        chk("mid_rst_grant", 32'(grant), 32'h0);
        step(1'b0, 10'h3FF, '0, 1'b1, 1'b0, "mid_after");
        chk("mid_after_id", {grant_valid, grant_id}, {1'b1, 4'd0});

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            rq = N'($urandom) & N'($urandom);
            hq = N'($urandom) & N'($urandom) & N'($urandom);
            step(($urandom_range(0, 59) == 0), rq, hq, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
